// File: rtl/core_pkg.sv
// core_pkg: shared decode enums, ALU control struct and RV32I opcode constants
package core_pkg;
    typedef enum logic [3:0] {
        OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL
    } OpCode;
    typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR} DecodedAluCmd;
    typedef logic [4:0] RegAddr;
    typedef struct packed {
        DecodedAluCmd cmd;
        logic         carry_in;
    } AluCtrl;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
endpackage

// File: rtl/nibble_alu.sv
// nibble_alu: combinational 4-bit ALU step; SUB is a + ~b + carry_in
module nibble_alu
    import core_pkg::*;
(
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  AluCtrl     ctrl,
    output logic [3:0] res,
    output logic       carry_out
);
    logic [4:0] sum;
    logic       arith;
    always_comb begin
        sum = {1'b0, d1} + {1'b0, ctrl.cmd == SUB ? ~d2 : d2} + {4'd0, ctrl.carry_in};
        arith = ctrl.cmd == ADD || ctrl.cmd == SUB;
        res = ctrl.cmd == AND ? d1 & d2 :
              ctrl.cmd == OR  ? d1 | d2 :
              ctrl.cmd == XOR ? d1 ^ d2 : sum[3:0];
        carry_out = arith & sum[4];
    end
endmodule

// File: rtl/decode_nibble_alu.sv
// decode_nibble_alu: registered RV32I field decode plus nibble-serial ALU with carry flag
module decode_nibble_alu
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    input  logic [31:0]  instr,
    output OpCode        op_class,
    output DecodedAluCmd alu_cmd,
    output RegAddr       rs1,
    output RegAddr       rs2,
    output RegAddr       rd,
    output logic [11:0]  jump_addr,
    input  logic         nib_start,
    input  logic         nib_en,
    input  logic [3:0]   nib_a,
    input  logic [3:0]   nib_b,
    output logic [3:0]   nib_res,
    output logic         carry_out
);
    OpCode        class_d;
    DecodedAluCmd cmd_d;
    logic [11:0]  imm_d;
    logic [2:0]   f3;
    logic         carry_flag;
    AluCtrl       ctrl;
    always_comb begin
        f3 = instr[14:12];
        class_d = instr[6:0] == OPC_OP     ? OP     :
                  instr[6:0] == OPC_OP_IMM ? OP_IMM :
                  instr[6:0] == OPC_LOAD   ? LOAD   :
                  instr[6:0] == OPC_STORE  ? STORE  :
                  instr[6:0] == OPC_BRANCH ? BRANCH :
                  instr[6:0] == OPC_JAL    ? JAL    :
                  instr[6:0] == OPC_JALR   ? JALR   :
                  instr[6:0] == OPC_LUI    ? LUI    :
                  instr[6:0] == OPC_AUIPC  ? AUIPC  : ILLEGAL;
        cmd_d = !(class_d == OP || class_d == OP_IMM) ? ADD :
                f3 == 3'b000 ? (class_d == OP && instr[30] ? SUB : ADD) :
                f3 == 3'b100 ? XOR :
                f3 == 3'b110 ? OR  :
                f3 == 3'b111 ? AND : ADD;
        // Branch offsets are stored halved: bit 0 of the byte offset is always zero
        imm_d = class_d == LOAD || class_d == OP_IMM || class_d == JALR ? instr[31:20] :
                class_d == STORE  ? {instr[31:25], instr[11:7]} :
                class_d == BRANCH ? {instr[31], instr[7], instr[30:25], instr[11:8]} : 12'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_class  <= ILLEGAL;
            alu_cmd   <= ADD;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            jump_addr <= '0;
        end else if (instr_valid) begin
            op_class  <= class_d;
            alu_cmd   <= cmd_d;
            rs1       <= instr[19:15];
            rs2       <= instr[24:20];
            rd        <= instr[11:7];
            jump_addr <= imm_d;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) carry_flag <= 1'b0;
        else if (nib_en) carry_flag <= carry_out;
    end
    always_comb begin
        ctrl.cmd = alu_cmd;
        ctrl.carry_in = nib_start ? alu_cmd == SUB : carry_flag;
    end
    nibble_alu u_alu (
        .d1       (nib_a),
        .d2       (nib_b),
        .ctrl     (ctrl),
        .res      (nib_res),
        .carry_out(carry_out)
    );
endmodule

// File: tb/tb_decode_nibble_alu.sv
// tb_decode_nibble_alu: directed decode and nibble-chain vectors with hand-computed results
module tb_decode_nibble_alu;
    import core_pkg::*;
    logic         clk = 0;
    logic         reset;
    logic         instr_valid;
    logic [31:0]  instr;
    OpCode        op_class;
    DecodedAluCmd alu_cmd;
    RegAddr       rs1, rs2, rd;
    logic [11:0]  jump_addr;
    logic         nib_start, nib_en;
    logic [3:0]   nib_a, nib_b, nib_res;
    logic         carry_out;
    int           total = 0;
    int           bad = 0;
    logic [31:0]  r;

    decode_nibble_alu dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .op_class(op_class), .alu_cmd(alu_cmd), .rs1(rs1), .rs2(rs2), .rd(rd),
        .jump_addr(jump_addr), .nib_start(nib_start), .nib_en(nib_en),
        .nib_a(nib_a), .nib_b(nib_b), .nib_res(nib_res), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic decode(input logic [31:0] w);
        @(negedge clk);
        instr = w;
        instr_valid = 1;
        @(negedge clk);
        instr_valid = 0;
        #1;
    endtask

    task automatic nibble(input bit start, input logic [3:0] a, input logic [3:0] b, output logic [3:0] res);
        @(negedge clk);
        nib_start = start;
        nib_en = 1;
        nib_a = a;
        nib_b = b;
        #1 res = nib_res;
    endtask

    task automatic chain(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res);
        logic [3:0] n;
        for (int i = 0; i < 8; i++) begin
            nibble(i == 0, a[4*i+:4], b[4*i+:4], n);
            res[4*i+:4] = n;
        end
        @(negedge clk);
        nib_en = 0;
        nib_start = 0;
    endtask

    // With ADD selected, F + 0 + flag exposes the stored carry flag on carry_out
    task automatic probe_flag(output logic f);
        nib_start = 0;
        nib_a = 4'hF;
        nib_b = 4'h0;
        #1 f = carry_out;
    endtask

    initial begin
        logic f;
        logic [3:0] n;
        reset = 1; instr_valid = 0; instr = 0;
        nib_start = 0; nib_en = 0; nib_a = 0; nib_b = 0;
        #2;
        check("rst_class", 32'(op_class), 32'(ILLEGAL));
        check("rst_cmd", 32'(alu_cmd), 32'(ADD));
        check("rst_regs", {17'd0, rs1, rs2, rd}, 0);
        check("rst_imm", 32'(jump_addr), 0);
        probe_flag(f);
        check("rst_flag", 32'(f), 0);
        @(negedge clk) reset = 0;

        decode(32'h002081B3);
        check("add_class", 32'(op_class), 32'(OP));
        check("add_cmd", 32'(alu_cmd), 32'(ADD));
        check("add_regs", {17'd0, rs1, rs2, rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        check("add_imm", 32'(jump_addr), 0);

        @(negedge clk);
        instr = 32'h402081B3;
        #1 check("hold_cmd", 32'(alu_cmd), 32'(ADD));
        decode(32'h402081B3);
        check("sub_cmd", 32'(alu_cmd), 32'(SUB));
        chain(32'h00000005, 32'h00000006, r);
        check("sub_chain", r, 32'hFFFFFFFF);

        decode(32'h0020C1B3);
        check("xor_cmd", 32'(alu_cmd), 32'(XOR));
        chain(32'h0F0F00FF, 32'h00FF0F0F, r);
        check("xor_chain", r, 32'h0FF00FF0);

        decode(32'hFFF00293);
        check("addi_class", 32'(op_class), 32'(OP_IMM));
        check("addi_regs", {22'd0, rs1, rd}, {22'd0, 5'd0, 5'd5});
        check("addi_imm", 32'(jump_addr), 32'hFFF);
        check("addi_cmd", 32'(alu_cmd), 32'(ADD));

        decode(32'h0020A423);
        check("sw_class", 32'(op_class), 32'(STORE));
        check("sw_imm", 32'(jump_addr), 8);

        decode(32'h00208463);
        check("beq_class", 32'(op_class), 32'(BRANCH));
        check("beq_regs", {22'd0, rs1, rs2}, {22'd0, 5'd1, 5'd2});
        check("beq_imm", 32'(jump_addr), 4);

        chain(32'hEFFFFFFF, 32'h00000001, r);
        check("add_chain1", r, 32'hF0000000);
        chain(32'hFFFF0FFF, 32'h00000002, r);
        check("add_chain2", r, 32'hFFFF1001);

        chain(32'hFFFFFFFF, 32'h00000001, r);
        check("wrap_chain", r, 0);
        probe_flag(f);
        check("wrap_flag_kept", 32'(f), 1);
        chain(32'h00000001, 32'h00000001, r);
        check("start_discard", r, 2);

        for (int i = 0; i < 3; i++) nibble(i == 0, 4'hF, i == 0 ? 4'h1 : 4'h0, n);
        nibble(0, 4'hF, 4'h0, n);
        check("pre_rst_carry", 32'(carry_out), 1);
        @(posedge clk);
        #2 reset = 1;
        nib_en = 0;
        #1;
        check("mid_rst_class", 32'(op_class), 32'(ILLEGAL));
        check("mid_rst_regs", {17'd0, rs1, rs2, rd}, 0);
        check("mid_rst_imm", 32'(jump_addr), 0);
        probe_flag(f);
        check("mid_rst_flag", 32'(f), 0);
        @(negedge clk) reset = 0;

        decode(32'h002081B3);
        decode(32'h0000007F);
        check("ill_class", 32'(op_class), 32'(ILLEGAL));
        check("ill_cmd", 32'(alu_cmd), 32'(ADD));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
